// File: rtl/uart_frame_check.sv
// Receive-side UART frame checker: walks start, data (LSB first), optional parity
// and 1-2 stop bits, reporting the word, per-frame errors and saturating error counts.
module uart_frame_check #(
  parameter int DATA_WIDTH = 8,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  bit_valid,
  input  logic                  sampled_bit,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic                  two_stop,
  input  logic                  clr_cnt,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  strt_glitch,
  output logic                  busy,
  output logic [ERR_CNT_W-1:0]  par_err_cnt,
  output logic [ERR_CNT_W-1:0]  stp_err_cnt
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP1, STOP2} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_run_q, par_run_d;
  logic                  par_bad_q, par_bad_d;
  logic                  stp_bad_q, stp_bad_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  two_stop_q, two_stop_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  data_valid_q, data_valid_d;
  logic                  par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d;
  logic                  strt_glitch_q, strt_glitch_d;
  logic [ERR_CNT_W-1:0]  par_cnt_q, par_cnt_d;
  logic [ERR_CNT_W-1:0]  stp_cnt_q, stp_cnt_d;
  logic                  frame_end;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      shift_q       <= '0;
      par_run_q     <= 1'b0;
      par_bad_q     <= 1'b0;
      stp_bad_q     <= 1'b0;
      par_en_q      <= 1'b0;
      par_typ_q     <= 1'b0;
      two_stop_q    <= 1'b0;
      p_data_q      <= '0;
      data_valid_q  <= 1'b0;
      par_err_q     <= 1'b0;
      stp_err_q     <= 1'b0;
      strt_glitch_q <= 1'b0;
      par_cnt_q     <= '0;
      stp_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shift_q       <= shift_d;
      par_run_q     <= par_run_d;
      par_bad_q     <= par_bad_d;
      stp_bad_q     <= stp_bad_d;
      par_en_q      <= par_en_d;
      par_typ_q     <= par_typ_d;
      two_stop_q    <= two_stop_d;
      p_data_q      <= p_data_d;
      data_valid_q  <= data_valid_d;
      par_err_q     <= par_err_d;
      stp_err_q     <= stp_err_d;
      strt_glitch_q <= strt_glitch_d;
      par_cnt_q     <= par_cnt_d;
      stp_cnt_q     <= stp_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shift_d       = shift_q;
    par_run_d     = par_run_q;
    par_bad_d     = par_bad_q;
    stp_bad_d     = stp_bad_q;
    par_en_d      = par_en_q;
    par_typ_d     = par_typ_q;
    two_stop_d    = two_stop_q;
    par_err_d     = par_err_q;
    stp_err_d     = stp_err_q;
    strt_glitch_d = 1'b0;
    frame_end     = 1'b0;
    if (bit_valid) begin
      case (state_q)
        IDLE: begin
          if (sampled_bit) begin
            strt_glitch_d = 1'b1;
          end else begin
            par_en_d   = par_en;
            par_typ_d  = par_typ;
            two_stop_d = two_stop;
            par_err_d  = 1'b0;
            stp_err_d  = 1'b0;
            cnt_d      = '0;
            par_run_d  = 1'b0;
            par_bad_d  = 1'b0;
            stp_bad_d  = 1'b0;
            state_d    = DATA;
          end
        end
        DATA: begin
          // Shifting in from the top leaves the first bit received at the LSB.
          shift_d   = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
          par_run_d = par_run_q ^ sampled_bit;
          cnt_d     = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
            state_d = par_en_q ? PARITY : STOP1;
          end
        end
        PARITY: begin
          par_bad_d = ((par_run_q ^ sampled_bit) != par_typ_q);
          state_d   = STOP1;
        end
        STOP1: begin
          stp_bad_d = ~sampled_bit;
          if (two_stop_q) begin
            state_d = STOP2;
          end else begin
            frame_end = 1'b1;
            state_d   = IDLE;
          end
        end
        STOP2: begin
          stp_bad_d = stp_bad_q | ~sampled_bit;
          frame_end = 1'b1;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    p_data_d     = p_data_q;
    data_valid_d = 1'b0;
    par_cnt_d    = par_cnt_q;
    stp_cnt_d    = stp_cnt_q;
    // The final stop verdict is folded in the same cycle it is sampled.
    if (frame_end) begin
      p_data_d     = shift_q;
      par_err_d    = par_bad_d;
      stp_err_d    = stp_bad_d;
      data_valid_d = ~par_bad_d & ~stp_bad_d;
      if (par_bad_d && (par_cnt_q != '1)) par_cnt_d = par_cnt_q + ERR_CNT_W'(1);
      if (stp_bad_d && (stp_cnt_q != '1)) stp_cnt_d = stp_cnt_q + ERR_CNT_W'(1);
    end
    if (clr_cnt) begin
      par_cnt_d = '0;
      stp_cnt_d = '0;
    end
  end

  always_comb begin
    busy        = (state_q != IDLE);
    p_data      = p_data_q;
    data_valid  = data_valid_q;
    par_err     = par_err_q;
    stp_err     = stp_err_q;
    strt_glitch = strt_glitch_q;
    par_err_cnt = par_cnt_q;
    stp_err_cnt = stp_cnt_q;
  end

endmodule

// File: tb/tb_uart_frame_check.sv
// Directed bench for uart_frame_check: one 8-bit-counter instance and one
// 2-bit-counter instance share the same bit stream.
module tb_uart_frame_check;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       bit_valid = 1'b0;
  logic       sampled_bit = 1'b1;
  logic       par_en = 1'b0;
  logic       par_typ = 1'b0;
  logic       two_stop = 1'b0;
  logic       clr_cnt = 1'b0;

  logic [7:0] a_p_data;
  logic       a_dv, a_perr, a_serr, a_glitch, a_busy;
  logic [7:0] a_pcnt, a_scnt;
  logic [7:0] b_p_data;
  logic       b_dv, b_perr, b_serr, b_glitch, b_busy;
  logic [1:0] b_pcnt, b_scnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  uart_frame_check #(.DATA_WIDTH(8), .ERR_CNT_W(8)) u_a (
    .CLK(CLK), .RST(RST), .bit_valid(bit_valid), .sampled_bit(sampled_bit),
    .par_en(par_en), .par_typ(par_typ), .two_stop(two_stop), .clr_cnt(clr_cnt),
    .p_data(a_p_data), .data_valid(a_dv), .par_err(a_perr), .stp_err(a_serr),
    .strt_glitch(a_glitch), .busy(a_busy), .par_err_cnt(a_pcnt), .stp_err_cnt(a_scnt)
  );

  uart_frame_check #(.DATA_WIDTH(8), .ERR_CNT_W(2)) u_b (
    .CLK(CLK), .RST(RST), .bit_valid(bit_valid), .sampled_bit(sampled_bit),
    .par_en(par_en), .par_typ(par_typ), .two_stop(two_stop), .clr_cnt(clr_cnt),
    .p_data(b_p_data), .data_valid(b_dv), .par_err(b_perr), .stp_err(b_serr),
    .strt_glitch(b_glitch), .busy(b_busy), .par_err_cnt(b_pcnt), .stp_err_cnt(b_scnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the capturing posedge.
  task automatic send_bit(input logic b, input logic clr);
    bit_valid   = 1'b1;
    sampled_bit = b;
    clr_cnt     = clr;
    @(negedge CLK);
    bit_valid   = 1'b0;
    sampled_bit = 1'b1;
    clr_cnt     = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_data(input logic [7:0] d);
    for (int i = 0; i < 8; i++) send_bit(d[i], 1'b0);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic has_par, input logic pbit,
                            input logic has_s2, input logic s1, input logic s2,
                            input logic clr_last);
    send_bit(1'b0, 1'b0);
    send_data(d);
    if (has_par) send_bit(pbit, 1'b0);
    if (has_s2) begin
      send_bit(s1, 1'b0);
      send_bit(s2, clr_last);
    end else begin
      send_bit(s1, clr_last);
    end
  endtask

  initial begin
    idle(3);
    chk("rst_busy", a_busy, 0);
    chk("rst_p_data", a_p_data, 0);
    chk("rst_cnt", {a_pcnt, a_scnt}, 0);
    RST = 1'b1;
    idle(2);

    // Plain 8N1 frame
    send_bit(1'b0, 1'b0);
    chk("busy_after_start", a_busy, 1);
    send_data(8'hA5);
    send_bit(1'b1, 1'b0);
    chk("a5_p_data", a_p_data, 8'hA5);
    chk("a5_dv", a_dv, 1);
    chk("a5_errs", {a_perr, a_serr, a_busy}, 0);
    idle(1);
    chk("a5_dv_pulse", a_dv, 0);

    // Even parity, good then bad
    par_en = 1'b1; par_typ = 1'b0;
    send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("par_ok_dv", a_dv, 1);
    chk("par_ok_err", a_perr, 0);
    idle(2);
    send_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("par_bad_err", a_perr, 1);
    chk("par_bad_dv", a_dv, 0);
    chk("par_bad_cnt", a_pcnt, 1);
    chk("par_bad_p_data", a_p_data, 8'h07);
    idle(2);

    // Two stop bits, second one low, then clean
    par_en = 1'b0; two_stop = 1'b1;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("stp_bad_err", a_serr, 1);
    chk("stp_bad_par_cleared", a_perr, 0);
    chk("stp_bad_cnt", a_scnt, 1);
    chk("stp_bad_dv", a_dv, 0);
    idle(2);
    send_bit(1'b0, 1'b0);
    chk("stp_err_cleared_at_start", a_serr, 0);
    send_data(8'h3C);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    chk("stp_ok_dv", a_dv, 1);
    chk("stp_ok_p_data", a_p_data, 8'h3C);
    idle(2);

    // Start glitch
    two_stop = 1'b0;
    send_bit(1'b1, 1'b0);
    chk("glitch_pulse", a_glitch, 1);
    chk("glitch_busy", a_busy, 0);
    idle(1);
    chk("glitch_pulse_end", a_glitch, 0);
    chk("glitch_cnt", {a_pcnt, a_scnt}, {8'd1, 8'd1});

    // Config change mid-frame is ignored until next start
    send_bit(1'b0, 1'b0);
    par_en = 1'b1;
    send_data(8'hC3);
    send_bit(1'b1, 1'b0);
    chk("cfg_latch_dv", a_dv, 1);
    chk("cfg_latch_p_data", a_p_data, 8'hC3);
    idle(1);

    // Saturating counters
    par_typ = 1'b0;
    clr_cnt = 1'b1;
    idle(1);
    clr_cnt = 1'b0;
    chk("clr_cnt", {b_pcnt, b_scnt, a_pcnt, a_scnt}, 0);
    for (int k = 1; k <= 4; k++) begin
      send_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      chk($sformatf("sat_b_%0d", k), b_pcnt, (k > 3) ? 3 : k);
      chk($sformatf("sat_a_%0d", k), a_pcnt, k);
      idle(1);
    end
    send_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("clr_wins_b", b_pcnt, 0);
    chk("clr_wins_a", a_pcnt, 0);
    chk("clr_wins_err", a_perr, 1);
    idle(2);

    // Reset mid-frame
    send_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(1);
    par_en = 1'b0;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    #2 RST = 1'b0;
    #1;
    chk("arst_busy", a_busy, 0);
    chk("arst_p_data", a_p_data, 0);
    chk("arst_flags", {a_dv, a_perr, a_serr, a_glitch}, 0);
    chk("arst_cnt", a_pcnt, 0);
    idle(2);
    RST = 1'b1;
    idle(1);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("post_rst_p_data", a_p_data, 8'h5A);
    chk("post_rst_dv", a_dv, 1);
    chk("post_rst_errs", {a_perr, a_serr}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
